pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the RV32 core fetch stage.
- Generalises the basic load/increment PC with:
  - configurable width, reset vector and increment;
  - stall handling;
  - prioritised trap, redirect, call and return sources;
  - target-misalignment detection;
  - a circular return-address stack (RAS) of configurable depth.
- Sits between the branch/trap logic and instruction-memory address port; pc_out drives the fetch address directly.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, pc_out value after reset.
- PC_INC, 4, increment added on sequential advance.
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).
- IALIGN_BITS, 2, low target bits that must be zero; nonzero means misaligned.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  freezes inc/load/call/ret; trap and redirect still act
- pc_inc_en  in  1  advance pc by PC_INC
- pc_load_en  in  1  load pc_load_data
- pc_load_data  in  XLEN  plain load target
- redirect_en  in  1  branch/jump mispredict redirect
- redirect_target  in  XLEN  redirect target
- trap_en  in  1  exception/interrupt entry
- trap_vector  in  XLEN  trap handler address
- call_en  in  1  jump-and-link: jump to call_target, push pc_out+PC_INC
- call_target  in  XLEN  call target
- ret_en  in  1  return: jump to RAS top, pop
- ras_flush  in  1  empty the RAS
- pc_out  out  XLEN  current fetch PC (registered)
- misaligned  out  1  one-cycle pulse: rejected misaligned target
- misaligned_addr  out  XLEN  last rejected target, held until next rejection
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (async assert, sync release):
  - pc_out=RESET_VECTOR; misaligned, misaligned_addr, ras_underflow, ras_count = 0.
  - RAS storage and top pointer = 0.
- All outputs are registered. A request sampled at edge N is visible on pc_out after edge N.
- Source priority per cycle is trap > redirect > call > ret > load > inc > hold. Lower sources in the same cycle are dropped, not queued.
- stall=1 masks call, ret, load and inc; pc holds. Trap and redirect still apply.
- trap_en: pc<=trap_vector. No alignment check (vector is trusted). RAS untouched.
- redirect_en: if redirect_target low IALIGN_BITS are zero, pc<=redirect_target. Otherwise pc holds, misaligned=1, misaligned_addr<=target. RAS untouched.
- call_en, aligned target:
  - pc<=call_target; RAS[top]<=pc_out+PC_INC; top<=top+1 mod RAS_DEPTH.
  - ras_count<=min(count+1, RAS_DEPTH).
  - On full, the oldest entry is overwritten (circular) and the count saturates.
- call_en, misaligned target: pc holds, misaligned pulse, no push.
- ret_en, count>0: pc<=RAS[top-1]; top<=top-1; count<=count-1. No alignment check on popped values.
- ret_en, count=0: pc<=pc_out+PC_INC (falls through); ras_underflow=1 for one cycle; RAS unchanged.
- pc_load_en: pc<=pc_load_data, unchecked, for boot/debug.
- pc_inc_en: pc<=pc_out+PC_INC, modulo 2^XLEN (wraps 0xFFFF_FFFC->0x0000_0000).
- ras_flush: count<=0 and top<=0, applied before any same-cycle push. Flush+call leaves count=1 holding the new link address.
- misaligned and ras_underflow deassert the cycle after they pulse unless re-triggered.
- Reset asserted mid-operation overrides everything immediately, including a pending push.

Decomposition:
- Shared package (core_pkg): XLEN default, RESET_VECTOR, PC_INC, IALIGN_BITS constants; a pc_src_e enum {SRC_HOLD, SRC_INC, SRC_LOAD, SRC_RET, SRC_CALL, SRC_REDIRECT, SRC_TRAP} for the priority selector.
- One sub-module is natural: ras_stack (RAS_DEPTH x XLEN circular stack with push/pop/flush, top pointer, saturating count, empty/full). pc_unit_ras holds the priority mux, alignment check and pc register.

Test Plan:
- Reset and increment: release rst_n, pc_inc_en=1 for 3 cycles -> pc_out 0x0, 0x4, 0x8, 0xC.
- Load vs inc priority and stall: pc_load_en=1, data=0x100, pc_inc_en=1 -> pc_out=0x100; then stall=1 with inc -> holds 0x100; stall=1 with trap_en, vector 0x800 -> 0x800.
- Misaligned redirect: pc=0x200, redirect_target=0x302 -> pc stays 0x200, misaligned pulses once, misaligned_addr=0x302; next, target 0x300 -> pc=0x300, no pulse.
- Call/return nesting: pc=0x40 call 0x1000; pc=0x1000 call 0x2000 -> ras_count=2. ret -> pc=0x1004; ret -> pc=0x44; ret again -> pc=0x48, ras_underflow pulses, count=0.
- RAS overflow (RAS_DEPTH=4): 5 calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40 -> count=4. Pops return 0x44, 0x34, 0x24, 0x14, then underflow.
- Simultaneous events and async reset: trap+redirect+call in one cycle -> trap_vector wins, RAS unchanged. ras_flush+call -> count=1. rst_n low mid-call -> pc_out=RESET_VECTOR and count=0 without waiting for clk.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-stage constants and the PC source encoding used by the priority selector.
package core_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          PC_INC_DEF       = 4;
  localparam int          RAS_DEPTH_DEF    = 4;
  localparam int          IALIGN_BITS_DEF  = 2;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INC,
    SRC_LOAD,
    SRC_RET,
    SRC_CALL,
    SRC_REDIRECT,
    SRC_TRAP
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry and the count saturates.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [XLEN-1:0]          i_push_data,
  output logic [XLEN-1:0]          o_top_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_top;
  logic [PW:0]     r_count;
  logic [PW-1:0]   w_base_top;
  logic [PW:0]     w_base_count;

  // Flush takes effect before a same-cycle push, so the push lands in slot 0.
  assign w_base_top   = i_flush ? '0 : r_top;
  assign w_base_count = i_flush ? '0 : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_mem[w_base_top] <= i_push_data;
      r_top             <= w_base_top + PW'(1);
      if (w_base_count != (PW+1)'(DEPTH)) r_count <= w_base_count + (PW+1)'(1);
      else                                r_count <= w_base_count;
    end else if (i_flush) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_pop && r_count != '0) begin
      r_top   <= r_top - PW'(1);
      r_count <= r_count - (PW+1)'(1);
    end
  end

  assign o_top_data = r_mem[r_top - PW'(1)];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch program counter with prioritised trap/redirect/call/ret/load/inc sources,
// target alignment checking and a return-address stack.
module pc_unit_ras import core_pkg::*; #(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              PC_INC       = PC_INC_DEF,
  parameter int              RAS_DEPTH    = RAS_DEPTH_DEF,
  parameter int              IALIGN_BITS  = IALIGN_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        pc_inc_en,
  input  logic                        pc_load_en,
  input  logic [XLEN-1:0]             pc_load_data,
  input  logic                        redirect_en,
  input  logic [XLEN-1:0]             redirect_target,
  input  logic                        trap_en,
  input  logic [XLEN-1:0]             trap_vector,
  input  logic                        call_en,
  input  logic [XLEN-1:0]             call_target,
  input  logic                        ret_en,
  input  logic                        ras_flush,
  output logic [XLEN-1:0]             pc_out,
  output logic                        misaligned,
  output logic [XLEN-1:0]             misaligned_addr,
  output logic                        ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  pc_src_e         w_src;
  logic [XLEN-1:0] r_pc, r_mis_addr, w_pc_next, w_link, w_ras_top, w_mis_target;
  logic            r_mis, r_under;
  logic            w_redir_ok, w_call_ok, w_ras_empty, w_push, w_pop;
  logic            w_mis_fire, w_under_fire;

  assign w_link     = r_pc + XLEN'(PC_INC);
  assign w_redir_ok = (redirect_target[IALIGN_BITS-1:0] == '0);
  assign w_call_ok  = (call_target[IALIGN_BITS-1:0] == '0);

  // Stall only masks the fetch-local sources; trap and redirect always get through.
  always_comb begin
    w_src = SRC_HOLD;
    if (trap_en)          w_src = SRC_TRAP;
    else if (redirect_en) w_src = SRC_REDIRECT;
    else if (!stall) begin
      if (call_en)         w_src = SRC_CALL;
      else if (ret_en)     w_src = SRC_RET;
      else if (pc_load_en) w_src = SRC_LOAD;
      else if (pc_inc_en)  w_src = SRC_INC;
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (w_src)
      SRC_TRAP:     w_pc_next = trap_vector;
      SRC_REDIRECT: if (w_redir_ok) w_pc_next = redirect_target;
      SRC_CALL: begin
        if (w_call_ok) begin
          w_pc_next = call_target;
          w_push    = 1'b1;
        end
      end
      SRC_RET: begin
        if (!w_ras_empty) begin
          w_pc_next = w_ras_top;
          w_pop     = 1'b1;
        end else begin
          w_pc_next = w_link;
        end
      end
      SRC_LOAD:     w_pc_next = pc_load_data;
      SRC_INC:      w_pc_next = w_link;
      default:      w_pc_next = r_pc;
    endcase
  end

  assign w_mis_fire   = (w_src == SRC_REDIRECT && !w_redir_ok) || (w_src == SRC_CALL && !w_call_ok);
  assign w_mis_target = (w_src == SRC_CALL) ? call_target : redirect_target;
  assign w_under_fire = (w_src == SRC_RET) && w_ras_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
      r_under    <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_mis   <= w_mis_fire;
      r_under <= w_under_fire;
      if (w_mis_fire) r_mis_addr <= w_mis_target;
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (ras_flush),
    .i_push_data (w_link),
    .o_top_data  (w_ras_top),
    .o_count     (ras_count),
    .o_empty     (w_ras_empty)
  );

  assign pc_out          = r_pc;
  assign misaligned      = r_mis;
  assign misaligned_addr = r_mis_addr;
  assign ras_underflow   = r_under;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed scenarios plus a randomized run against a queue-based model of the PC and return stack.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, pc_inc_en, pc_load_en, redirect_en, trap_en, call_en, ret_en, ras_flush;
  logic [31:0] pc_load_data, redirect_target, trap_vector, call_target;
  logic [31:0] pc_out, misaligned_addr;
  logic        misaligned, ras_underflow;
  logic [2:0]  ras_count;

  int total = 0;
  int bad = 0;

  logic [31:0] mPc, mMisAddr;
  logic        mMis, mUnder;
  logic [31:0] mRas[$];

  always #5 clk = ~clk;

  pc_unit_ras #(
    .XLEN(32), .RESET_VECTOR(32'h0), .PC_INC(4), .RAS_DEPTH(4), .IALIGN_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_inc_en(pc_inc_en),
    .pc_load_en(pc_load_en), .pc_load_data(pc_load_data),
    .redirect_en(redirect_en), .redirect_target(redirect_target),
    .trap_en(trap_en), .trap_vector(trap_vector),
    .call_en(call_en), .call_target(call_target),
    .ret_en(ret_en), .ras_flush(ras_flush),
    .pc_out(pc_out), .misaligned(misaligned), .misaligned_addr(misaligned_addr),
    .ras_underflow(ras_underflow), .ras_count(ras_count)
  );

  task automatic clearInputs();
    stall = 0; pc_inc_en = 0; pc_load_en = 0; redirect_en = 0; trap_en = 0;
    call_en = 0; ret_en = 0; ras_flush = 0;
    pc_load_data = '0; redirect_target = '0; trap_vector = '0; call_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 0;
    #12;
    total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", pc_out, 32'h0); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", ras_count); end
    total++; if (misaligned !== 1'b0 || ras_underflow !== 1'b0 || misaligned_addr !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_flags got mis=%b und=%b addr=%h want 0/0/0", misaligned, ras_underflow, misaligned_addr);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      pc_inc_en = 1;
      tick();
      total++; if (pc_out !== 32'(4 * i)) begin bad++; $display("[TB] FAIL inc_%0d got=%h want=%h", i, pc_out, 32'(4 * i)); end
    end
  endtask

  task automatic test_load_stall();
    pc_load_en = 1; pc_load_data = 32'h100; pc_inc_en = 1;
    tick();
    total++; if (pc_out !== 32'h100) begin bad++; $display("[TB] FAIL load_over_inc got=%h want=%h", pc_out, 32'h100); end
    stall = 1; pc_inc_en = 1;
    tick();
    total++; if (pc_out !== 32'h100) begin bad++; $display("[TB] FAIL stall_hold got=%h want=%h", pc_out, 32'h100); end
    stall = 1; trap_en = 1; trap_vector = 32'h800;
    tick();
    total++; if (pc_out !== 32'h800) begin bad++; $display("[TB] FAIL stall_trap got=%h want=%h", pc_out, 32'h800); end
  endtask

  task automatic test_misaligned();
    pc_load_en = 1; pc_load_data = 32'h200;
    tick();
    redirect_en = 1; redirect_target = 32'h302;
    tick();
    total++; if (pc_out !== 32'h200) begin bad++; $display("[TB] FAIL mis_hold got=%h want=%h", pc_out, 32'h200); end
    total++; if (misaligned !== 1'b1 || misaligned_addr !== 32'h302) begin
      bad++; $display("[TB] FAIL mis_pulse got mis=%b addr=%h want 1/%h", misaligned, misaligned_addr, 32'h302);
    end
    tick();
    total++; if (misaligned !== 1'b0 || misaligned_addr !== 32'h302) begin
      bad++; $display("[TB] FAIL mis_clear got mis=%b addr=%h want 0/%h", misaligned, misaligned_addr, 32'h302);
    end
    redirect_en = 1; redirect_target = 32'h300;
    tick();
    total++; if (pc_out !== 32'h300 || misaligned !== 1'b0) begin
      bad++; $display("[TB] FAIL redirect_ok got pc=%h mis=%b want %h/0", pc_out, misaligned, 32'h300);
    end
  endtask

  task automatic test_call_ret();
    pc_load_en = 1; pc_load_data = 32'h40;
    tick();
    call_en = 1; call_target = 32'h1000;
    tick();
    call_en = 1; call_target = 32'h2000;
    tick();
    total++; if (pc_out !== 32'h2000 || ras_count !== 3'd2) begin
      bad++; $display("[TB] FAIL nest_call got pc=%h cnt=%0d want %h/2", pc_out, ras_count, 32'h2000);
    end
    ret_en = 1;
    tick();
    total++; if (pc_out !== 32'h1004) begin bad++; $display("[TB] FAIL ret1 got=%h want=%h", pc_out, 32'h1004); end
    ret_en = 1;
    tick();
    total++; if (pc_out !== 32'h44) begin bad++; $display("[TB] FAIL ret2 got=%h want=%h", pc_out, 32'h44); end
    ret_en = 1;
    tick();
    total++; if (pc_out !== 32'h48 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin
      bad++; $display("[TB] FAIL ret_underflow got pc=%h und=%b cnt=%0d want %h/1/0", pc_out, ras_underflow, ras_count, 32'h48);
    end
    tick();
    total++; if (ras_underflow !== 1'b0) begin bad++; $display("[TB] FAIL underflow_clear got=%b want=0", ras_underflow); end
  endtask

  task automatic test_overflow();
    logic [31:0] expect_pop [4];
    expect_pop = '{32'h44, 32'h34, 32'h24, 32'h14};
    pc_load_en = 1; pc_load_data = 32'h0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      call_en = 1; call_target = 32'(16 * i);
      tick();
    end
    total++; if (ras_count !== 3'd4) begin bad++; $display("[TB] FAIL overflow_count got=%0d want=4", ras_count); end
    for (int i = 0; i < 4; i++) begin
      ret_en = 1;
      tick();
      total++; if (pc_out !== expect_pop[i]) begin bad++; $display("[TB] FAIL overflow_pop%0d got=%h want=%h", i, pc_out, expect_pop[i]); end
    end
    ret_en = 1;
    tick();
    total++; if (pc_out !== 32'h18 || ras_underflow !== 1'b1) begin
      bad++; $display("[TB] FAIL overflow_underflow got pc=%h und=%b want %h/1", pc_out, ras_underflow, 32'h18);
    end
  endtask

  task automatic test_simultaneous();
    pc_load_en = 1; pc_load_data = 32'h500;
    tick();
    call_en = 1; call_target = 32'h600;
    tick();
    trap_en = 1; trap_vector = 32'hA00; redirect_en = 1; redirect_target = 32'h700;
    call_en = 1; call_target = 32'h900;
    tick();
    total++; if (pc_out !== 32'hA00 || ras_count !== 3'd1) begin
      bad++; $display("[TB] FAIL trap_wins got pc=%h cnt=%0d want %h/1", pc_out, ras_count, 32'hA00);
    end
    ras_flush = 1; call_en = 1; call_target = 32'hB00;
    tick();
    total++; if (pc_out !== 32'hB00 || ras_count !== 3'd1) begin
      bad++; $display("[TB] FAIL flush_call got pc=%h cnt=%0d want %h/1", pc_out, ras_count, 32'hB00);
    end
    ret_en = 1;
    tick();
    total++; if (pc_out !== 32'hA04 || ras_count !== 3'd0) begin
      bad++; $display("[TB] FAIL flush_call_ret got pc=%h cnt=%0d want %h/0", pc_out, ras_count, 32'hA04);
    end
  endtask

  task automatic test_async_reset();
    call_en = 1; call_target = 32'hC00;
    tick();
    call_en = 1; call_target = 32'hD00;
    #2;
    rst_n = 0;
    #1;
    total++; if (pc_out !== 32'h0 || ras_count !== 3'd0) begin
      bad++; $display("[TB] FAIL async_reset got pc=%h cnt=%0d want 0/0", pc_out, ras_count);
    end
    @(negedge clk);
    clearInputs();
    rst_n = 1;
    pc_inc_en = 1;
    tick();
    total++; if (pc_out !== 32'h4 || ras_count !== 3'd0) begin
      bad++; $display("[TB] FAIL after_reset got pc=%h cnt=%0d want 4/0", pc_out, ras_count);
    end
  endtask

  // Reference model: applies one cycle of the source rules to the model state.
  task automatic modelStep();
    logic [31:0] nxt, link;
    logic        mis, und, doPush;
    link = mPc + 32'd4;
    nxt = mPc; mis = 0; und = 0; doPush = 0;
    if (trap_en) nxt = trap_vector;
    else if (redirect_en) begin
      if (redirect_target % 4 == 0) nxt = redirect_target;
      else begin mis = 1; mMisAddr = redirect_target; end
    end else if (!stall) begin
      if (call_en) begin
        if (call_target % 4 == 0) begin nxt = call_target; doPush = 1; end
        else begin mis = 1; mMisAddr = call_target; end
      end else if (ret_en) begin
        if (mRas.size() > 0) nxt = mRas.pop_back();
        else begin nxt = link; und = 1; end
      end else if (pc_load_en) nxt = pc_load_data;
      else if (pc_inc_en) nxt = link;
    end
    if (ras_flush) mRas.delete();
    if (doPush) begin
      if (mRas.size() == 4) void'(mRas.pop_front());
      mRas.push_back(link);
    end
    mPc = nxt; mMis = mis; mUnder = und;
  endtask

  function automatic logic [31:0] genAddr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  task automatic test_random();
    rst_n = 0;
    #3;
    @(negedge clk);
    rst_n = 1;
    mPc = 32'h0; mMisAddr = 32'h0; mMis = 0; mUnder = 0; mRas.delete();
    for (int n = 0; n < 400; n++) begin
      stall       = ($urandom_range(0, 9) == 0);
      trap_en     = ($urandom_range(0, 19) == 0);
      redirect_en = ($urandom_range(0, 9) == 0);
      call_en     = ($urandom_range(0, 3) == 0);
      ret_en      = ($urandom_range(0, 3) == 0);
      pc_load_en  = ($urandom_range(0, 9) == 0);
      pc_inc_en   = ($urandom_range(0, 1) == 0);
      ras_flush   = ($urandom_range(0, 24) == 0);
      trap_vector = genAddr();
      redirect_target = genAddr();
      call_target = genAddr();
      pc_load_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : genAddr();
      modelStep();
      tick();
      total++; if (pc_out !== mPc) begin bad++; $display("[TB] FAIL rnd_pc[%0d] got=%h want=%h", n, pc_out, mPc); end
      total++; if (ras_count !== 3'(mRas.size())) begin bad++; $display("[TB] FAIL rnd_count[%0d] got=%0d want=%0d", n, ras_count, mRas.size()); end
      total++; if (misaligned !== mMis || misaligned_addr !== mMisAddr) begin
        bad++; $display("[TB] FAIL rnd_mis[%0d] got %b/%h want %b/%h", n, misaligned, misaligned_addr, mMis, mMisAddr);
      end
      total++; if (ras_underflow !== mUnder) begin bad++; $display("[TB] FAIL rnd_und[%0d] got=%b want=%b", n, ras_underflow, mUnder); end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_load_stall();
    test_misaligned();
    test_call_ret();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
